// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NREQ requesters.
// A round-robin grant picks one request, its operands are registered onto
// the ALU inputs, the ALU result is captured one cycle later, and it is
// returned with the owner's ID on a valid/ready response channel.

`ifndef ALU_NOP
`define ALU_NOP 8'h00
`endif

module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2,
  parameter int N    = 16,
  parameter int C    = 8,
  parameter int S    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*C-1:0] req_opcode,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*S-1:0] req_shift,
  output logic [C-1:0]      alu_opcode,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [S-1:0]      alu_shift,
  input  logic [N-1:0]      alu_y,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N-1:0]      resp_data,
  output logic [IW-1:0]     resp_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_rrPtr;
  logic [IW-1:0] r_curId;
  logic [C-1:0]  r_aluOpcode;
  logic [N-1:0]  r_aluA;
  logic [N-1:0]  r_aluB;
  logic [S-1:0]  r_aluShift;
  logic          r_respValid;
  logic [N-1:0]  r_respData;
  logic [IW-1:0] r_respId;

  logic          w_grantValid;
  logic [IW-1:0] w_grantIdx;
  logic [C-1:0]  w_selOpcode;
  logic [N-1:0]  w_selA;
  logic [N-1:0]  w_selB;
  logic [S-1:0]  w_selShift;

  // Round-robin scan starting at the pointer; walking the offsets from the
  // far end backwards lets the nearest valid requester overwrite the others.
  always_comb begin : grantScan
    logic [IW-1:0] scanIdx;
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    scanIdx      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scanIdx = IW'((int'(r_rrPtr) + k) % NREQ);
      if (req_valid[scanIdx]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = scanIdx;
      end
    end
  end

  // One-hot accept to the winner, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (!rst && r_state == IDLE && w_grantValid) begin
      for (int i = 0; i < NREQ; i++) begin
        req_ready[i] = (IW'(i) == w_grantIdx);
      end
    end
  end

  // Select the winner's operands out of the packed request buses.
  always_comb begin
    w_selOpcode = '0;
    w_selA      = '0;
    w_selB      = '0;
    w_selShift  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == w_grantIdx) begin
        w_selOpcode = req_opcode[i*C +: C];
        w_selA      = req_a[i*N +: N];
        w_selB      = req_b[i*N +: N];
        w_selShift  = req_shift[i*S +: S];
      end
    end
  end

  // Control FSM: grant in IDLE, one ALU evaluation cycle in ISSUE, hold the
  // result in RESP until the consumer takes it. ALU registers keep their last
  // operation after completion; only reset returns them to NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rrPtr     <= '0;
      r_curId     <= '0;
      r_aluOpcode <= C'(`ALU_NOP);
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluShift  <= '0;
      r_respValid <= 1'b0;
      r_respData  <= '0;
      r_respId    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_aluOpcode <= w_selOpcode;
            r_aluA      <= w_selA;
            r_aluB      <= w_selB;
            r_aluShift  <= w_selShift;
            r_curId     <= w_grantIdx;
            r_rrPtr     <= (w_grantIdx == IW'(NREQ - 1)) ? '0 : w_grantIdx + 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_respData  <= alu_y;
          r_respId    <= r_curId;
          r_respValid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_respValid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign alu_opcode = r_aluOpcode;
  assign alu_a      = r_aluA;
  assign alu_b      = r_aluB;
  assign alu_shift  = r_aluShift;
  assign resp_valid = r_respValid;
  assign resp_data  = r_respData;
  assign resp_id    = r_respId;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// run checked against a queue-free behavioural model of the arbitration rules.

module tb_alu_arbiter;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_AND   = 8'h03;
  localparam logic [7:0] OP_OR    = 8'h04;
  localparam logic [7:0] OP_XOR   = 8'h05;
  localparam logic [7:0] OP_ADD_I = 8'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_opcode;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [19:0] req_shift;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_shift;
  logic [15:0] alu_y;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [1:0]  resp_id;

  logic [7:0]  opArr[4];
  logic [15:0] aArr[4];
  logic [15:0] bArr[4];
  logic [4:0]  shArr[4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign req_opcode[g*8 +: 8] = opArr[g];
    assign req_a[g*16 +: 16]    = aArr[g];
    assign req_b[g*16 +: 16]    = bArr[g];
    assign req_shift[g*5 +: 5]  = shArr[g];
  end

  // Behavioural ALU sitting behind the arbiter.
  function automatic logic [15:0] aluModel(input logic [7:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [4:0] sh);
    int sum;
    case (op)
      OP_NOP:   return 16'h0000;
      OP_ADD:   return (a << sh) + b;
      OP_SUB:   return a - b;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_ADD_I: begin
        sum = int'($signed(a)) + int'($signed(b));
        if (sum > 32767) return 16'h7FFF;
        if (sum < -32768) return 16'h8000;
        return sum[15:0];
      end
      default:  return ~a;
    endcase
  endfunction

  assign alu_y = aluModel(alu_opcode, alu_a, alu_b, alu_shift);

  alu_arbiter #(.NREQ(4), .IW(2), .N(16), .C(8), .S(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_shift(alu_shift),
    .alu_y(alu_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic [7:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [4:0] sh);
    opArr[i] = op;
    aArr[i]  = a;
    bArr[i]  = b;
    shArr[i] = sh;
  endtask

  function automatic logic [7:0] randOp();
    case ($urandom_range(0, 7))
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_AND;
      3: return OP_OR;
      4: return OP_XOR;
      5: return OP_ADD_I;
      6: return OP_NOP;
      default: return 8'($urandom_range(32, 255));
    endcase
  endfunction

  task automatic randReq(input int i);
    setReq(i, randOp(), 16'($urandom), 16'($urandom), 5'($urandom_range(0, 20)));
  endtask

  task automatic doReset();
    rst        = 1'b1;
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) randReq(i);
    req_valid = 4'b1111;
    #3;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_ready got %b want 0000", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 16'h0 || resp_id !== 2'd0) begin
      errors++; $display("[TB] FAIL reset_resp got v=%b d=%h id=%0d want 0/0/0", resp_valid, resp_data, resp_id);
    end
    checks++;
    if (alu_opcode !== OP_NOP || alu_a !== 16'h0 || alu_b !== 16'h0 || alu_shift !== 5'd0) begin
      errors++; $display("[TB] FAIL reset_alu got op=%h a=%h b=%h sh=%0d want 00/0/0/0", alu_opcode, alu_a, alu_b, alu_shift);
    end
    doReset();
    checks++;
    if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle got ready=%b rv=%b want 0000/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_single();
    doReset();
    setReq(2, OP_ADD, 16'd3, 16'd1, 5'd2);
    req_valid  = 4'b0100;
    resp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("[TB] FAIL single_ready got %b want 0100", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (alu_a !== 16'd3 || alu_opcode !== OP_ADD || alu_b !== 16'd1 || alu_shift !== 5'd2) begin
      errors++; $display("[TB] FAIL single_alu got op=%h a=%0d b=%0d sh=%0d want 01/3/1/2", alu_opcode, alu_a, alu_b, alu_shift);
    end
    checks++;
    if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_issue got ready=%b rv=%b want 0000/0", req_ready, resp_valid);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 16'd13 || resp_id !== 2'd2) begin
      errors++; $display("[TB] FAIL single_resp got v=%b d=%0d id=%0d want 1/13/2", resp_valid, resp_data, resp_id);
    end
    resp_ready = 1'b1;
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_done got rv=%b want 0", resp_valid);
    end
    checks++;
    if (alu_opcode !== OP_ADD || alu_a !== 16'd3) begin
      errors++; $display("[TB] FAIL single_hold got op=%h a=%0d want 01/3", alu_opcode, alu_a);
    end
  endtask

  task automatic test_round_robin();
    int expOrder[5] = '{0, 1, 2, 3, 0};
    int gap;
    doReset();
    for (int i = 0; i < 4; i++) randReq(i);
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (req_ready !== 4'(1 << expOrder[n])) begin
        errors++; $display("[TB] FAIL rr_grant%0d got %b want %b", n, req_ready, 4'(1 << expOrder[n]));
      end
      tick();
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(expOrder[n]) ||
          resp_data !== aluModel(opArr[expOrder[n]], aArr[expOrder[n]], bArr[expOrder[n]], shArr[expOrder[n]])) begin
        errors++; $display("[TB] FAIL rr_resp%0d got v=%b id=%0d d=%h want id=%0d", n, resp_valid, resp_id, resp_data, expOrder[n]);
      end
      gap = 1;
      while (req_ready === 4'b0000 && gap < 10) begin
        tick();
        gap++;
      end
      checks++;
      if (gap !== 2) begin
        errors++; $display("[TB] FAIL rr_gap%0d got %0d want 2 cycles from response to next grant", n, gap);
      end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_wrap();
    doReset();
    resp_ready = 1'b1;
    randReq(0); randReq(1); randReq(2);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("[TB] FAIL wrap_first got %b want 0100", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("[TB] FAIL wrap_grant0 got %b want 0001", req_ready);
    end
    tick();
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("[TB] FAIL wrap_grant1 got %b want 0010", req_ready);
    end
    req_valid = 4'b0000;
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] expData;
    doReset();
    for (int i = 0; i < 4; i++) randReq(i);
    req_valid  = 4'b1111;
    resp_ready = 1'b0;
    #1;
    expData = aluModel(opArr[0], aArr[0], bArr[0], shArr[0]);
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== expData || resp_id !== 2'd0 || req_ready !== 4'b0000) begin
        errors++; $display("[TB] FAIL bp_hold%0d got v=%b d=%h id=%0d ready=%b want 1/%h/0/0000",
                           c, resp_valid, resp_data, resp_id, req_ready, expData);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      errors++; $display("[TB] FAIL bp_release got rv=%b ready=%b want 0/0010", resp_valid, req_ready);
    end
    req_valid = 4'b0000;
    tick(); tick(); tick();
  endtask

  task automatic test_saturation();
    doReset();
    setReq(1, OP_ADD_I, 16'h7000, 16'h7000, 5'd0);
    req_valid  = 4'b0010;
    resp_ready = 1'b0;
    tick();
    req_valid = 4'b0000;
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 16'h7FFF || resp_id !== 2'd1) begin
      errors++; $display("[TB] FAIL sat_resp got v=%b d=%h id=%0d want 1/7fff/1", resp_valid, resp_data, resp_id);
    end
    resp_ready = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    doReset();
    for (int i = 0; i < 4; i++) randReq(i);
    opArr[0]   = OP_XOR;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    tick();
    checks++;
    if (alu_opcode !== OP_XOR) begin
      errors++; $display("[TB] FAIL ar_issue got op=%h want %h", alu_opcode, OP_XOR);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || alu_opcode !== OP_NOP || alu_a !== 16'h0 || req_ready !== 4'b0000) begin
      errors++; $display("[TB] FAIL ar_immediate got rv=%b op=%h a=%h ready=%b want 0/00/0/0000",
                         resp_valid, alu_opcode, alu_a, req_ready);
    end
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL ar_noresp%0d got rv=%b want 0", c, resp_valid);
      end
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("[TB] FAIL ar_restart got %b want 0001", req_ready);
    end
    req_valid = 4'b0000;
    #1;
  endtask

  // Model: a set of pending requesters and a "next to consider" position.
  task automatic test_random();
    logic [3:0]  pend;
    int          ptr;
    int          g;
    logic [7:0]  eOp;
    logic [15:0] eA, eB, eY;
    logic [4:0]  eSh;
    doReset();
    pend = 4'b0000;
    ptr  = 0;
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          randReq(i);
          pend[i] = 1'b1;
        end else if (pend[i] && $urandom_range(0, 9) == 0) begin
          pend[i] = 1'b0;
        end
      end
      if (pend == 4'b0000) begin
        g = $urandom_range(0, 3);
        randReq(g);
        pend[g] = 1'b1;
      end
      req_valid  = pend;
      resp_ready = 1'b0;
      #1;
      g = -1;
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && pend[(ptr + k) % 4]) g = (ptr + k) % 4;
      end
      checks++;
      if (req_ready !== 4'(1 << g)) begin
        errors++; $display("[TB] FAIL rnd_grant t=%0d got %b want %b", t, req_ready, 4'(1 << g));
      end
      eOp = opArr[g]; eA = aArr[g]; eB = bArr[g]; eSh = shArr[g];
      eY  = aluModel(eOp, eA, eB, eSh);
      tick();
      ptr = (g + 1) % 4;
      if ($urandom_range(0, 2) == 0) randReq(g);
      else pend[g] = 1'b0;
      req_valid = pend;
      checks++;
      if (alu_opcode !== eOp || alu_a !== eA || alu_b !== eB || alu_shift !== eSh) begin
        errors++; $display("[TB] FAIL rnd_alu t=%0d got %h/%h/%h/%0d want %h/%h/%h/%0d",
                           t, alu_opcode, alu_a, alu_b, alu_shift, eOp, eA, eB, eSh);
      end
      tick();
      for (int c = 0; c <= $urandom_range(0, 3); c++) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== eY || resp_id !== 2'(g) || req_ready !== 4'b0000) begin
          errors++; $display("[TB] FAIL rnd_resp t=%0d got v=%b d=%h id=%0d ready=%b want 1/%h/%0d/0000",
                             t, resp_valid, resp_data, resp_id, req_ready, eY, g);
        end
        if (c > 0) tick();
      end
      resp_ready = 1'b1;
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL rnd_done t=%0d got rv=%b want 0", t, resp_valid);
      end
    end
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) setReq(i, OP_NOP, 16'h0, 16'h0, 5'd0);
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 16-bit ALU among NREQ requesters using round-robin arbitration.
- Each requester presents opcode/A/B/shift on a valid/ready handshake.
- The arbiter latches the winning operation, drives the ALU, and captures Y into a result register.
- The result is returned with the winner's ID on a valid/ready response channel. The block sits between the datapath issue stages and the single ALU instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IW, 2, requester ID width; must satisfy 2**IW >= NREQ.
- N, 16, operand/result width.
- C, 8, opcode width.
- S, 5, shift width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_opcode  in  NREQ*C  packed opcodes; requester i occupies bits [i*C +: C].
- req_a  in  NREQ*N  packed A operands.
- req_b  in  NREQ*N  packed B operands.
- req_shift  in  NREQ*S  packed shift amounts.
- alu_opcode  out  C  to ALU opcode, registered.
- alu_a  out  N  to ALU A, registered.
- alu_b  out  N  to ALU B, registered.
- alu_shift  out  S  to ALU shift, registered.
- alu_y  in  N  ALU result, combinational from alu_* outputs.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  N  captured ALU result.
- resp_id  out  IW  index of the requester that owns resp_data.

Behaviour:
- Reset (async, immediate) sets:
  - state=IDLE, rr_ptr=0.
  - alu_opcode=`ALU_NOP, alu_a=0, alu_b=0, alu_shift=0.
  - resp_valid=0, resp_data=0, resp_id=0.
  - req_ready=0 during reset.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... NREQ-1 then wrapping to 0.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0. If no request is valid, req_ready=0 and the block stays in IDLE.
  - On the handshake edge: latch req_*[g] into the alu_* registers, latch g into cur_id, set rr_ptr = (g+1) mod NREQ, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - alu_* are stable from the registers.
  - On the edge: resp_data<=alu_y, resp_id<=cur_id, resp_valid<=1, go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_id are held stable.
  - When resp_valid && resp_ready on an edge: resp_valid<=0, go to IDLE.
  - Backpressure is unlimited; no new grant is made while in RESP.
- req_ready is 0 in ISSUE and RESP.
- alu_* registers hold their last operation after completion; they are not cleared to NOP.
- Latency: request accepted at edge k, resp_valid high after edge k+1, first possible response handshake at edge k+2. Maximum throughput is one operation per 3 cycles with resp_ready tied high.
- Fairness: a continuously-valid requester waits at most NREQ-1 grants between services.
- Requester identity is tracked by cur_id; there is no combinational path from alu_y to resp_data.
- Simultaneous events:
  - Requests arriving during ISSUE or RESP wait; no request is dropped while its valid is held.
  - A requester dropping valid before its handshake is legal; it is not granted.
- rr_ptr only advances on a grant, never on idle cycles.
- Reset mid-operation abandons the in-flight operation; no response is produced for it.
- Opcode is passed through unmodified; the arbiter does no decoding. Undefined opcodes yield whatever the ALU returns.
- req_* inputs are sampled only on the handshake edge.

Test Plan:
- Single request:
  - Stimulus: after reset, req_valid=4'b0100, opcode=`ALU_ADD, A=3, B=1, shift=2.
  - Required: req_ready=4'b0100 in the same cycle; alu_a=3 after the edge; resp_valid 2 cycles later with resp_data=13, resp_id=2.
- Round-robin:
  - Stimulus: req_valid=4'b1111 held, resp_ready=1.
  - Required: grant order 0,1,2,3,0; one grant every 3 cycles.
- Pointer wrap/skip:
  - Stimulus: rr_ptr=3 after granting 2, then req_valid=4'b0011.
  - Required: grant 0, then 1.
- Backpressure:
  - Stimulus: resp_ready=0 for 10 cycles, other requests pending.
  - Required: resp_valid, resp_data and resp_id stable; req_ready=0 throughout; release → IDLE next cycle, grant follows.
- Saturation pass-through:
  - Stimulus: `ALU_ADD_I with A=16'h7000, B=16'h7000.
  - Required: resp_data=16'h7FFF, matching the ALU model.
- Async reset:
  - Stimulus: rst asserted mid-ISSUE (between edges).
  - Required: resp_valid=0, alu_opcode=`ALU_NOP immediately; no response after release; next grant starts at requester 0.
